// File: rtl/axi_err_slave_if.sv
// AXI4 subset used by the error slave: AW/W/B/AR/R handshake signals.
// wdata/wstrb are deliberately absent because the terminator never inspects them.
interface axi_err_slave_if #(
  parameter int ID_WIDTH   = 5,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]   awid;
  logic [7:0]            awlen;
  logic                  awvalid;
  logic                  awready;

  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awid, awlen, awvalid,
    output awready,
    input  wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, arlen, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awlen, awvalid,
    input  awready,
    output wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, arlen, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_err_slave.sv
// Terminating AXI4 slave: accepts any burst, drains write data and answers
// every transaction with DECERR so unmapped accesses never hang a master.
// Keeps a saturating count of completed error transactions for debug.
module axi_err_slave #(
  parameter int          ID_WIDTH      = 5,
  parameter int          DATA_WIDTH    = 64,
  parameter logic [63:0] RDATA_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF,
  parameter int          CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_err_slave_if.slave       s_axi,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Write path state and registered outputs
  w_state_t             r_wr_state;
  w_state_t             w_wr_next;
  logic                 r_awready;
  logic                 r_wready;
  logic                 r_bvalid;
  logic [ID_WIDTH-1:0]  r_bid;

  // Read path state and registered outputs
  r_state_t             r_rd_state;
  r_state_t             w_rd_next;
  logic                 r_arready;
  logic                 r_rvalid;
  logic                 r_rlast;
  logic [ID_WIDTH-1:0]  r_rid;
  logic [7:0]           r_rcnt;
  logic [7:0]           w_rcnt_next;

  // Error counter
  logic [CNT_WIDTH-1:0] r_err_cnt;
  logic [CNT_WIDTH-1:0] w_err_next;
  logic [CNT_WIDTH:0]   w_err_sum;
  logic [1:0]           w_err_inc;

  // Handshakes are qualified with the registered ready/valid outputs
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_rfinal_hs;

  assign w_aw_hs     = s_axi.awvalid & r_awready;
  assign w_w_hs      = s_axi.wvalid  & r_wready;
  assign w_b_hs      = r_bvalid      & s_axi.bready;
  assign w_ar_hs     = s_axi.arvalid & r_arready;
  assign w_r_hs      = r_rvalid      & s_axi.rready;
  assign w_rfinal_hs = w_r_hs & r_rlast;

  // Write FSM next state: address, drain beats until wlast, then one B response
  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      W_IDLE: begin
        if (w_aw_hs) w_wr_next = W_DATA;
        else         w_wr_next = W_IDLE;
      end
      W_DATA: begin
        if (w_w_hs && s_axi.wlast) w_wr_next = W_RESP;
        else                       w_wr_next = W_DATA;
      end
      W_RESP: begin
        if (w_b_hs) w_wr_next = W_IDLE;
        else        w_wr_next = W_RESP;
      end
      default: w_wr_next = W_IDLE;
    endcase
  end

  // Write FSM state register; readies/valids are registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bid      <= {ID_WIDTH{1'b0}};
    end else begin
      r_wr_state <= w_wr_next;
      r_awready  <= (w_wr_next == W_IDLE);
      r_wready   <= (w_wr_next == W_DATA);
      r_bvalid   <= (w_wr_next == W_RESP);
      if (w_aw_hs) r_bid <= s_axi.awid;
      else         r_bid <= r_bid;
    end
  end

  // Read FSM next state and beat counter: counter holds beats remaining after the current one
  always_comb begin
    w_rd_next   = r_rd_state;
    w_rcnt_next = r_rcnt;
    case (r_rd_state)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rd_next   = R_DATA;
          w_rcnt_next = s_axi.arlen;
        end else begin
          w_rd_next   = R_IDLE;
          w_rcnt_next = r_rcnt;
        end
      end
      R_DATA: begin
        if (w_rfinal_hs) begin
          w_rd_next   = R_IDLE;
          w_rcnt_next = 8'd0;
        end else if (w_r_hs) begin
          w_rd_next   = R_DATA;
          w_rcnt_next = r_rcnt - 8'd1;
        end else begin
          w_rd_next   = R_DATA;
          w_rcnt_next = r_rcnt;
        end
      end
      default: begin
        w_rd_next   = R_IDLE;
        w_rcnt_next = 8'd0;
      end
    endcase
  end

  // Read FSM state register; rlast is precomputed so it is stable across stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rid      <= {ID_WIDTH{1'b0}};
      r_rcnt     <= 8'd0;
    end else begin
      r_rd_state <= w_rd_next;
      r_arready  <= (w_rd_next == R_IDLE);
      r_rvalid   <= (w_rd_next == R_DATA);
      r_rlast    <= (w_rd_next == R_DATA) && (w_rcnt_next == 8'd0);
      r_rcnt     <= w_rcnt_next;
      if (w_ar_hs) r_rid <= s_axi.arid;
      else         r_rid <= r_rid;
    end
  end

  // Saturating increment: B and final-R completions may land in the same cycle
  always_comb begin
    w_err_inc = {1'b0, w_b_hs} + {1'b0, w_rfinal_hs};
    w_err_sum = {1'b0, r_err_cnt} + {{(CNT_WIDTH - 1){1'b0}}, w_err_inc};
    if (w_err_sum[CNT_WIDTH]) begin
      w_err_next = {CNT_WIDTH{1'b1}};
    end else begin
      w_err_next = w_err_sum[CNT_WIDTH-1:0];
    end
  end

  // Error counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      r_err_cnt <= w_err_next;
    end
  end

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bid     = r_bid;
  assign s_axi.bresp   = RESP_DECERR;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rlast   = r_rlast;
  assign s_axi.rid     = r_rid;
  assign s_axi.rresp   = RESP_DECERR;
  assign s_axi.rdata   = RDATA_PATTERN[DATA_WIDTH-1:0];
  assign err_cnt       = r_err_cnt;

endmodule

// File: doc/axi_err_slave.md
# axi_err_slave

Terminating AXI4 slave for crossbar master ports whose address window maps to no real target. It accepts every write and read burst, consumes all write data and returns DECERR responses with correct ID and beat count, so an errant access never hangs the initiator. It also keeps a saturating count of rejected transactions for debug. It sits directly downstream of the crossbar wrapper, so its ID width is the crossbar's widened output ID (input ID width plus $clog2 of the initiator count).

## Interface
- ID_WIDTH, 5: AXI ID width; equals the crossbar output ID width.
- DATA_WIDTH, 64: R/W data width.
- RDATA_PATTERN, 64'hDEAD_BEEF_DEAD_BEEF: value driven on rdata, truncated to DATA_WIDTH.
- CNT_WIDTH, 16: width of the error counter.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- awid  in  ID_WIDTH; awlen  in  8; awvalid  in  1; awready  out  1
- wlast  in  1; wvalid  in  1; wready  out  1 (wdata/wstrb not ported, ignored)
- bid  out  ID_WIDTH; bresp  out  2; bvalid  out  1; bready  in  1
- arid  in  ID_WIDTH; arlen  in  8; arvalid  in  1; arready  out  1
- rid  out  ID_WIDTH; rdata  out  DATA_WIDTH; rresp  out  2; rlast  out  1; rvalid  out  1; rready  in  1
- err_cnt  out  CNT_WIDTH  count of completed DECERR transactions, saturating

## Operation
- Write and read paths are independent FSMs; each path has at most one transaction outstanding.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. An AW handshake latches awid and moves to W_DATA.
  - W_DATA: wready=1. Beats are consumed. A handshake with wlast=1 moves to W_RESP. awlen is ignored for termination; wlast alone ends the burst.
  - W_RESP: bvalid=1, bid=latched id, bresp=2'b11. A B handshake returns to W_IDLE.
  - W beats presented before AW are stalled (wready=0 outside W_DATA).
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. An AR handshake latches arid and loads beat counter = arlen.
  - R_DATA: rvalid=1, rid=latched id, rresp=2'b11, rdata=RDATA_PATTERN, rlast=(counter==0).
  - Each R handshake decrements the counter. A handshake with rlast returns to R_IDLE.
  - rid/rdata/rresp/rlast hold stable while rvalid && !rready.
- err_cnt: +1 on each B handshake, +1 on each final (rlast) R handshake, +2 when both occur in the same cycle. Saturates at all-ones; never wraps.
- bresp/rresp are constant 2'b11. bid/rid are 0 until first latched.

## Timing
- Reset values while rst=1, all registered: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, bid=0, rid=0, err_cnt=0. FSMs are in W_IDLE/R_IDLE, but the ready outputs are forced low.
- First rising edge after rst falls: awready=1 and arready=1 from the next cycle.
- AW handshake at edge t: awready=0 and wready=1 from t+1.
- wlast handshake at t: wready=0 and bvalid=1 from t+1.
- B handshake at t: bvalid=0 and awready=1 from t+1. Write turnaround is at least 3 cycles with a 1-beat burst.
- AR handshake at t: rvalid=1 from t+1. With rready held high, beats arrive back-to-back at one per cycle, so arlen+1 cycles.
- Final R handshake at t: rvalid=0 and arready=1 from t+1.
- err_cnt updates one cycle after the qualifying handshake.
- Reset asserted mid-burst: outputs take reset values immediately (asynchronous). The transaction is dropped and no response is issued after reset release.
- arlen=255: 256 beats, counter is 8 bits with no overflow. arlen=0: the first beat has rlast=1.

## Test plan
- Single write: awid=5'h13, awlen=0, one wlast beat, bready=1 -> bvalid 1 cycle after the wlast handshake, bid=5'h13, bresp=2'b11, err_cnt=1.
- Read burst with backpressure: arid=5'h07, arlen=3, rready toggling 1,0,1,0... -> exactly 4 beats, rdata=RDATA_PATTERN, rresp=2'b11, rlast only on the 4th, outputs stable during stalls, arready back 1 cycle after the last beat.
- Early W data: wvalid with wlast=1 driven 3 cycles before awvalid -> wready=0 until the cycle after the AW handshake, then the beat is accepted and B is returned.
- Concurrent final B and final R handshakes in the same cycle, err_cnt=10 beforehand -> err_cnt=12.
- Saturation: CNT_WIDTH=4, 17 single-beat reads -> err_cnt stops at 4'hF.
- Reset mid-read: arlen=7, rst asserted after 3 beats -> rvalid=0 immediately, arready=1 one cycle after release, and no further R beats.
